voice_allocator: RTL



---
 rtl/voice_pkg.sv | 20 ++
 rtl/voice_pick.sv | 32 +++
 rtl/voice_allocator.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/voice_pkg.sv
// Shared types and defaults for the polyphonic voice allocator.
package voice_pkg;

   localparam int NOTE_W     = 7;
   localparam int AGE_W      = 8;
   localparam int NUM_VOICES = 4;

   typedef enum logic [1:0] {
      IDLE,
      DECIDE,
      STEAL,
      ASSIGN
   } state_t;

   // LSB position of voice `voice` inside a packed per-voice note vector.
   function automatic int note_lsb(input int voice, input int note_w);
      return voice * note_w;
   endfunction

endpackage

// File: rtl/voice_pick.sv
// Combinational selector: index of the oldest candidate voice, ties to lowest index.
module voice_pick #(
   parameter int N     = 4,
   parameter int AGE_W = 8
) (
   input  logic [N-1:0]         mask,
   input  logic [N*AGE_W-1:0]   ages,
   output logic [$clog2(N)-1:0] idx,
   output logic                 found
);

   localparam int IDX_W = $clog2(N);

   logic [AGE_W-1:0] best;

   // NOTE: every variable assigned in always_comb gets a default first, so no
   // path leaves it holding its old value and no latch is inferred.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      best  = '0;
      // Strict greater-than keeps the earliest index on equal ages.
      for (int i = 0; i < N; i++) begin
         if (mask[i] && (!found || ages[i*AGE_W +: AGE_W] > best)) begin
            found = 1'b1;
            idx   = IDX_W'(i);
            best  = ages[i*AGE_W +: AGE_W];
         end
      end
   end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: maps note-on/off events onto ADSR voices,
// retriggers held notes and steals the oldest voice when all are gated.
module voice_allocator #(
   parameter int NUM_VOICES = voice_pkg::NUM_VOICES,
   parameter int NOTE_W     = voice_pkg::NOTE_W,
   parameter int AGE_W      = voice_pkg::AGE_W,
   parameter int STEAL_GAP  = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         ev_valid,
   output logic                         ev_ready,
   input  logic                         ev_on,
   input  logic [NOTE_W-1:0]            ev_note,
   input  logic [NUM_VOICES-1:0]        env_active,
   output logic [NUM_VOICES-1:0]        gate,
   output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
   output logic [NUM_VOICES-1:0]        retrig
);

   import voice_pkg::*;

   localparam int IDX_W = $clog2(NUM_VOICES);
   localparam int CNT_W = $clog2(STEAL_GAP + 1);
   localparam logic [AGE_W-1:0] AGE_MAX = '1;

   state_t                      state, state_nx;
   logic                        cap_on;
   logic [NOTE_W-1:0]           cap_note;
   logic [IDX_W-1:0]            target;
   logic [CNT_W-1:0]            gap_cnt;
   logic [NUM_VOICES*AGE_W-1:0] ages;

   logic                        match_found;
   logic [IDX_W-1:0]            match_idx;
   logic [NUM_VOICES-1:0]       free_mask, rel_mask, pick_mask;
   logic [NUM_VOICES*AGE_W-1:0] pick_ages;
   logic [IDX_W-1:0]            pick_idx;
   logic                        pick_found;

   assign ev_ready = (state == IDLE);

   // Lowest-index gated voice already holding the captured note.
   always_comb begin
      match_found = 1'b0;
      match_idx   = '0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (gate[i] && voice_note[note_lsb(i, NOTE_W) +: NOTE_W] == cap_note) begin
            match_found = 1'b1;
            match_idx   = IDX_W'(i);
         end
      end
   end

   // One picker serves all three classes; zeroed ages turn it into a
   // lowest-index encoder for the free class.
   assign free_mask = ~gate & ~env_active;
   assign rel_mask  = ~gate & env_active;
   assign pick_mask = (|free_mask) ? free_mask : (|rel_mask) ? rel_mask : gate;
   assign pick_ages = (|free_mask) ? '0 : ages;

   voice_pick #(
      .N     (NUM_VOICES),
      .AGE_W (AGE_W)
   ) u_pick (
      .mask  (pick_mask),
      .ages  (pick_ages),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (ev_valid) state_nx = DECIDE;
         DECIDE: begin
            state_nx = IDLE;
            if (cap_on && !match_found && pick_found)
               state_nx = (&gate) ? STEAL : ASSIGN;
         end
         STEAL:   if (gap_cnt == CNT_W'(STEAL_GAP - 1)) state_nx = ASSIGN;
         ASSIGN:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cap_on     <= 1'b0;
         cap_note   <= '0;
         target     <= '0;
         gap_cnt    <= '0;
         gate       <= '0;
         retrig     <= '0;
         voice_note <= '0;
         ages       <= '0;
      end else begin
         retrig <= '0;
         case (state)
            IDLE: begin
               if (ev_valid) begin
                  cap_on   <= ev_on;
                  cap_note <= ev_note;
               end
            end
            DECIDE: begin
               if (cap_on) begin
                  if (match_found) begin
                     retrig[match_idx]                           <= 1'b1;
                     ages[int'(match_idx)*AGE_W +: AGE_W]        <= '0;
                  end else begin
                     target  <= pick_idx;
                     gap_cnt <= '0;
                     if (&gate) gate[pick_idx] <= 1'b0;
                  end
               end else if (match_found) begin
                  gate[match_idx] <= 1'b0;
               end
            end
            STEAL: gap_cnt <= gap_cnt + CNT_W'(1);
            ASSIGN: begin
               voice_note[note_lsb(int'(target), NOTE_W) +: NOTE_W] <= cap_note;
               gate[target] <= 1'b1;
               for (int i = 0; i < NUM_VOICES; i++) begin
                  if (IDX_W'(i) == target)
                     ages[i*AGE_W +: AGE_W] <= '0;
                  else if (ages[i*AGE_W +: AGE_W] != AGE_MAX)
                     ages[i*AGE_W +: AGE_W] <= ages[i*AGE_W +: AGE_W] + AGE_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
